cordic_fix2float: RTL
=====================

// Module: cordic_fix2float
// PURPOSE
//  Multi-cycle converter: signed fixed-point CORDIC datapath value (Q2.WIDTH, two's complement) -> IEEE-754 single.
//  Back end of the cosine unit: takes the cos term from the CORDIC array and produces the float result.
//  Nios-II custom-instruction style start/done handshake.
// PARAMETERS
//  WIDTH  24  fractional bits of input; input word is WIDTH+2 bits (sign + 1 integer + WIDTH fraction)
// PORTS
//  clk      in   1        system clock; all state on rising edge
//  reset_n  in   1        asynchronous, active-low reset
//  clk_en   in   1        clock enable; low freezes all state (FSM, regs, done)
//  start    in   1        1-cycle request; dataa sampled same edge
//  dataa    in   WIDTH+2  signed fixed input, value = dataa * 2^-WIDTH
//  done     out  1        1-cycle pulse: result valid
//  result   out  32       IEEE-754 single; held until next conversion completes
// BEHAVIOUR
//  - Reset: state=IDLE, done=0, result=32'h0, internal regs 0; reset mid-conversion aborts, no done.
//  - FSM IDLE -> LOAD -> NORM -> PACK -> IDLE. Only states; encoding in package.
//  - IDLE: start&clk_en -> capture dataa, go LOAD. start in any other state ignored (no queueing).
//  - LOAD: sign=dataa[MSB]; mag = |dataa| as WIDTH+2-bit unsigned (|-2^(WIDTH+1)| fits);
//    exp = 127+WIDTH+1-WIDTH = 128 (leading-bit position WIDTH+1). mag==0 -> zero flag, go PACK; else NORM.
//  - NORM: while mag[MSB]==0: mag<<=1, exp-=1, one bit per cycle; mag[MSB]==1 -> PACK.
//    Cycles in NORM = (WIDTH+1)-p, p = leading-one index of |dataa|.
//  - PACK: mantissa = mag[MSB-1 -: 23]; remaining low bits are guard/sticky. Register result, pulse done, go IDLE.
//    zero flag -> result=32'h00000000 (sign forced 0, no -0).
//  - Latency start->done: 3 + (WIDTH+1-p) edges; zero input: 3. WIDTH=24: 1.0 -> 4, 2^-24 -> 28.
//  - Exponent 8-bit, never under/overflows for WIDTH<=100; no denormals, inf or NaN ever produced.
//  - done high exactly one cycle; with clk_en low, done and all state hold.
// CONFIGURATION
//  ROUND_NEAREST_EN defined: round-to-nearest-even on the 23-bit mantissa using guard + sticky
//    (OR of rest). Mantissa carry-out -> mantissa=0, exp+=1, in the same PACK cycle; latency unchanged.
//  Not defined: truncate toward zero (magnitude); guard/sticky logic absent.
// STRUCTURE
//  cordic_pkg: FP_BIAS=127, FP_EXP_W=8, FP_MAN_W=23, fsm state typedef, fixed-word width function of WIDTH.
//  One sub-module: cordic_fp_pack (combinational: sign, exp, normalised mag -> 32-bit word, incl. rounding).
//  FSM, abs, shifter and exponent counter in this module.
// TESTING (WIDTH=24; check result and done-cycle count)
//  dataa=26'h1000000 (1.0) -> 32'h3F800000, done 4 cycles after start
//  dataa=26'h3000000 (-1.0) -> 32'hBF800000; dataa=26'h2000000 (-2.0) -> 32'hC0000000, done after 3
//  dataa=26'h0000001 (2^-24) -> 32'h33800000, done after 28; dataa=0 -> 32'h00000000, done after 3
//  dataa=26'h1FFFFFF: ROUND_NEAREST_EN -> 32'h40000000 (carry bumps exp); without -> 32'h3FFFFFFF
//  start pulses every cycle during a conversion -> ignored, single done, result from first dataa only
//  reset_n low mid-NORM -> result 0, done 0, no pulse; clk_en low 5 cycles mid-NORM -> latency +5, same result

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants, FSM state encoding and width helper for the CORDIC fixed-to-float back end.
package cordic_pkg;

  localparam int FP_BIAS  = 127;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_NORM = 2'd2,
    ST_PACK = 2'd3
  } state_e;

  // Input word: sign + one integer bit + WIDTH fraction bits.
  function automatic int fix_w(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/cordic_fp_pack.sv
// Combinational packer: sign, exponent and normalised magnitude -> IEEE-754 single.
// ROUND_NEAREST_EN selects round-to-nearest-even; otherwise the mantissa is truncated.
module cordic_fp_pack
  import cordic_pkg::*;
#(
  parameter int DATA_W = 26
) (
  input  logic                sign,
  input  logic                zero,
  input  logic [FP_EXP_W-1:0] exp_in,
  input  logic [DATA_W-1:0]   mag,
  output logic [31:0]         word
);

  localparam int EXT_W = DATA_W + FP_MAN_W;
  localparam int SH    = DATA_W - 1;

  logic [EXT_W-1:0]    ext;
  logic [FP_MAN_W-1:0] man_t;
  logic [FP_MAN_W-1:0] man_o;
  logic [FP_EXP_W-1:0] exp_o;

  // Zero padding keeps the slice valid when the fixed word is narrower than the mantissa.
  assign ext = {mag, {FP_MAN_W{1'b0}}};

`ifdef ROUND_NEAREST_EN
  logic [FP_MAN_W:0] man_r;

  function automatic logic [FP_MAN_W:0] rne(input logic [FP_MAN_W-1:0] man,
                                            input logic guard, input logic sticky);
    logic up;
    up = guard & (sticky | man[0]);
    return {1'b0, man} + {{FP_MAN_W{1'b0}}, up};
  endfunction
`endif

  always_comb begin
    man_t = FP_MAN_W'(ext >> SH);
    man_o = man_t;
    exp_o = exp_in;
`ifdef ROUND_NEAREST_EN
    man_r = rne(man_t, ext[SH-1], |ext[SH-2:0]);
    if (man_r[FP_MAN_W]) begin
      man_o = '0;
      exp_o = exp_in + FP_EXP_W'(1);
    end else begin
      man_o = man_r[FP_MAN_W-1:0];
    end
`endif
    word = zero ? 32'h0000_0000 : {sign, exp_o, man_o};
  end

endmodule

// File: rtl/cordic_fix2float.sv
// Multi-cycle Q2.WIDTH signed fixed -> IEEE-754 single converter with start/done handshake.
// Normalises one bit per cycle; rounding mode chosen by ROUND_NEAREST_EN in cordic_fp_pack.
module cordic_fix2float
  import cordic_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk_en,
  input  logic             start,
  input  logic [WIDTH+1:0] dataa,
  output logic             done,
  output logic [31:0]      result
);

  localparam int FW = fix_w(WIDTH);
  // Leading bit of the fixed word carries weight 2^1.
  localparam logic [FP_EXP_W-1:0] EXP_TOP = FP_EXP_W'(FP_BIAS + WIDTH + 1 - WIDTH);

  state_e              state_q, state_d;
  logic [FW-1:0]       data_q, data_d;
  logic                sign_q, sign_d;
  logic                zero_q, zero_d;
  logic [FW-1:0]       mag_q, mag_d;
  logic [FP_EXP_W-1:0] exp_q, exp_d;
  logic [31:0]         result_q, result_d;
  logic                done_q, done_d;

  logic [FW-1:0]       abs_val;
  logic [31:0]         packed_word;

  cordic_fp_pack #(
    .DATA_W (FW)
  ) u_pack (
    .sign   (sign_q),
    .zero   (zero_q),
    .exp_in (exp_q),
    .mag    (mag_q),
    .word   (packed_word)
  );

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    sign_d   = sign_q;
    zero_d   = zero_q;
    mag_d    = mag_q;
    exp_d    = exp_q;
    result_d = result_q;
    done_d   = 1'b0;
    // Negating -2^(WIDTH+1) wraps to the same bit pattern, which is the correct unsigned magnitude.
    abs_val  = data_q[FW-1] ? -data_q : data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          data_d  = dataa;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        sign_d  = data_q[FW-1];
        mag_d   = abs_val;
        exp_d   = EXP_TOP;
        zero_d  = (abs_val == '0);
        state_d = ((abs_val == '0) || abs_val[FW-1]) ? ST_PACK : ST_NORM;
      end
      ST_NORM: begin
        mag_d = mag_q << 1;
        exp_d = exp_q - FP_EXP_W'(1);
        if (mag_q[FW-2]) state_d = ST_PACK;
      end
      ST_PACK: begin
        result_d = packed_word;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      mag_q    <= '0;
      exp_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else if (clk_en) begin
      state_q  <= state_d;
      data_q   <= data_d;
      sign_q   <= sign_d;
      zero_q   <= zero_d;
      mag_q    <= mag_d;
      exp_q    <= exp_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule
